// File: rtl/bus_port_fifo.sv
// bus_port_fifo
// One bus port with two independent first-word-fall-through FIFOs:
//   TX: driver writes (wr_en/wr_data), bus arbiter sees pndng/D_pop and
//       consumes the head with pop.
//   RX: bus delivers D_push with push; only packets addressed to this port's
//       id (or the broadcast id) are kept. Monitor reads with rd_en/rd_data.
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   wr_en, wr_data      TX write strobe and packet
//   tx_full, tx_count   TX status
//   pndng, D_pop        TX non-empty flag and head packet (0 while empty)
//   pop                 bus consumes TX head
//   push, D_push        bus delivers a packet to this port
//   rd_en, rd_data      RX read strobe and head packet (0 while empty)
//   rx_valid, rx_count  RX status
//   tx_drop, rx_ovf, misroute  saturating 8-bit event counters
//
// Strobe semantics: every strobe (wr_en, pop, push, rd_en) is a single-cycle
// request sampled on the rising edge. A request that cannot be honoured is
// dropped (and counted where a counter exists) -- there is no back-pressure
// and no retry. Any strobe sampled while reset=1 is ignored.
module bus_port_fifo #(
  parameter int          pckg_sz   = 16,
  parameter int          depth     = 8,
  parameter logic [7:0]  id        = 8'd0,
  parameter logic [7:0]  broadcast = 8'hFF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [pckg_sz-1:0]         wr_data,
  output logic                       tx_full,
  output logic [$clog2(depth):0]     tx_count,
  output logic                       pndng,
  output logic [pckg_sz-1:0]         D_pop,
  input  logic                       pop,
  input  logic                       push,
  input  logic [pckg_sz-1:0]         D_push,
  input  logic                       rd_en,
  output logic [pckg_sz-1:0]         rd_data,
  output logic                       rx_valid,
  output logic [$clog2(depth):0]     rx_count,
  output logic [7:0]                 tx_drop,
  output logic [7:0]                 rx_ovf,
  output logic [7:0]                 misroute
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(depth);

  // Storage is not reset; outputs are masked while the FIFO is empty.
  logic [pckg_sz-1:0] tx_mem_q [depth];
  logic [pckg_sz-1:0] rx_mem_q [depth];

  logic [AW-1:0] tx_rd_ptr_q, tx_rd_ptr_d;
  logic [AW-1:0] tx_wr_ptr_q, tx_wr_ptr_d;
  logic [CW-1:0] tx_count_q,  tx_count_d;
  logic [AW-1:0] rx_rd_ptr_q, rx_rd_ptr_d;
  logic [AW-1:0] rx_wr_ptr_q, rx_wr_ptr_d;
  logic [CW-1:0] rx_count_q,  rx_count_d;
  logic [7:0]    tx_drop_q,   tx_drop_d;
  logic [7:0]    rx_ovf_q,    rx_ovf_d;
  logic [7:0]    misroute_q,  misroute_d;

  logic       tx_pop_ok, tx_wr_ok;
  logic       rx_rd_ok,  rx_wr_ok;
  logic       dst_match;
  logic [7:0] dst;

  assign dst       = D_push[pckg_sz-1 -: 8];
  assign dst_match = (dst == id) || (dst == broadcast);

  // ---------------- TX path ----------------
  always_comb begin
    // A pop frees a slot in the same cycle, so a write into a full FIFO
    // is accepted when it coincides with a valid pop.
    tx_pop_ok   = !reset && pop && (tx_count_q != '0);
    tx_wr_ok    = !reset && wr_en && ((tx_count_q != FULL_CNT) || tx_pop_ok);
    tx_rd_ptr_d = tx_rd_ptr_q;
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_count_d  = tx_count_q;
    tx_drop_d   = tx_drop_q;
    if (tx_pop_ok) tx_rd_ptr_d = tx_rd_ptr_q + AW'(1);
    if (tx_wr_ok)  tx_wr_ptr_d = tx_wr_ptr_q + AW'(1);
    case ({tx_wr_ok, tx_pop_ok})
      2'b10:   tx_count_d = tx_count_q + CW'(1);
      2'b01:   tx_count_d = tx_count_q - CW'(1);
      default: tx_count_d = tx_count_q;
    endcase
    if (!reset && wr_en && !tx_wr_ok && (tx_drop_q != 8'hFF))
      tx_drop_d = tx_drop_q + 8'd1;
  end

  // ---------------- RX path ----------------
  always_comb begin
    rx_rd_ok    = !reset && rd_en && (rx_count_q != '0);
    rx_wr_ok    = !reset && push && dst_match &&
                  ((rx_count_q != FULL_CNT) || rx_rd_ok);
    rx_rd_ptr_d = rx_rd_ptr_q;
    rx_wr_ptr_d = rx_wr_ptr_q;
    rx_count_d  = rx_count_q;
    rx_ovf_d    = rx_ovf_q;
    misroute_d  = misroute_q;
    if (rx_rd_ok) rx_rd_ptr_d = rx_rd_ptr_q + AW'(1);
    if (rx_wr_ok) rx_wr_ptr_d = rx_wr_ptr_q + AW'(1);
    case ({rx_wr_ok, rx_rd_ok})
      2'b10:   rx_count_d = rx_count_q + CW'(1);
      2'b01:   rx_count_d = rx_count_q - CW'(1);
      default: rx_count_d = rx_count_q;
    endcase
    if (!reset && push && dst_match && !rx_wr_ok && (rx_ovf_q != 8'hFF))
      rx_ovf_d = rx_ovf_q + 8'd1;
    if (!reset && push && !dst_match && (misroute_q != 8'hFF))
      misroute_d = misroute_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_rd_ptr_q <= '0;
      tx_wr_ptr_q <= '0;
      tx_count_q  <= '0;
      rx_rd_ptr_q <= '0;
      rx_wr_ptr_q <= '0;
      rx_count_q  <= '0;
      tx_drop_q   <= '0;
      rx_ovf_q    <= '0;
      misroute_q  <= '0;
    end else begin
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_count_q  <= tx_count_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_count_q  <= rx_count_d;
      tx_drop_q   <= tx_drop_d;
      rx_ovf_q    <= rx_ovf_d;
      misroute_q  <= misroute_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_wr_ok) tx_mem_q[tx_wr_ptr_q] <= wr_data;
    if (rx_wr_ok) rx_mem_q[rx_wr_ptr_q] <= D_push;
  end

  assign tx_count = tx_count_q;
  assign tx_full  = (tx_count_q == FULL_CNT);
  assign pndng    = (tx_count_q != '0);
  assign D_pop    = pndng ? tx_mem_q[tx_rd_ptr_q] : '0;

  assign rx_count = rx_count_q;
  assign rx_valid = (rx_count_q != '0);
  assign rd_data  = rx_valid ? rx_mem_q[rx_rd_ptr_q] : '0;

  assign tx_drop  = tx_drop_q;
  assign rx_ovf   = rx_ovf_q;
  assign misroute = misroute_q;

endmodule
